// File: rtl/control_unit_pipe.sv
// Decode stage with a registered control bundle, load-use stall, multi-cycle divide hold and flush.
// The bundle registers one cycle after accept; write enables are gated by out_valid.
module control_unit_pipe #(
  parameter int OP_W    = 4,
  parameter int REG_W   = 4,
  parameter int DIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  OpCode,
  input  logic [REG_W-1:0] rs_a,
  input  logic [REG_W-1:0] rs_b,
  input  logic [REG_W-1:0] rd,
  input  logic             flush,
  output logic             out_valid,
  output logic [1:0]       BranchSelect,
  output logic             RegFileWE,
  output logic [1:0]       ExtendSelect,
  output logic             ALUOpBSelect,
  output logic [1:0]       ALUControl,
  output logic             SetFlags,
  output logic             MemWE,
  output logic             WBSelect,
  output logic             illegal,
  output logic             div_busy
);

  localparam int CW = $clog2(DIV_LAT) + 1;

  typedef enum logic {RUN, DIV_WAIT} state_t;

  typedef struct packed {
    logic [1:0] bsel;
    logic       rfwe;
    logic [1:0] ext;
    logic       alub;
    logic [1:0] aluc;
    logic       setf;
    logic       memwe;
    logic       wbsel;
  } ctl_t;

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt, w_ncnt;
  ctl_t            r_ctl, w_dec;
  logic [REG_W-1:0] r_rd;
  logic            r_out_valid, r_illegal;
  logic            w_illegal, w_stall, w_ready, w_acc;
  logic            w_nvalid, w_nill, w_load, w_zero;

  always_comb begin
    w_dec     = '0;
    w_illegal = |(OpCode >> 4);
    case (OpCode[3:0])
      4'h0: ;
      4'h1: begin w_dec.bsel = 2'b01; w_dec.ext = 2'b10; w_dec.aluc = 2'b01; w_dec.setf = 1'b1; end
      4'h2: begin w_dec.bsel = 2'b10; w_dec.ext = 2'b10; w_dec.aluc = 2'b01; w_dec.setf = 1'b1; end
      4'h3: begin w_dec.bsel = 2'b11; w_dec.ext = 2'b10; w_dec.aluc = 2'b01; w_dec.setf = 1'b1; end
      4'h4, 4'h5: begin w_dec.rfwe = 1'b1; w_dec.wbsel = 1'b1; end
      4'h6, 4'h7: w_dec.memwe = 1'b1;
      4'h8: w_dec.rfwe = 1'b1;
      4'h9: begin w_dec.rfwe = 1'b1; w_dec.ext = 2'b01; w_dec.alub = 1'b1; end
      4'hA: begin w_dec.rfwe = 1'b1; w_dec.aluc = 2'b01; end
      4'hB: begin w_dec.rfwe = 1'b1; w_dec.aluc = 2'b10; end
      4'hC: begin w_dec.rfwe = 1'b1; w_dec.aluc = 2'b11; end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) w_dec = '0;
  end

  // A live load whose destination feeds the incoming instruction costs one bubble.
  assign w_stall = (r_state == RUN) && in_valid && r_out_valid && r_ctl.wbsel &&
                   ((r_rd == rs_a) || (r_rd == rs_b)) && !flush;
  assign w_ready = rst_n && (r_state == RUN) && !w_stall;
  assign w_acc   = in_valid && w_ready;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nvalid = 1'b0;
    w_nill   = 1'b0;
    w_load   = 1'b0;
    w_zero   = 1'b0;
    if (flush) begin
      w_nstate = RUN;
      w_ncnt   = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_acc) begin
            if (w_illegal) begin
              w_nill = 1'b1;
              w_zero = 1'b1;
            end else begin
              w_load = 1'b1;
              if ((OpCode[3:0] == 4'hB) && (DIV_LAT > 1)) begin
                w_nstate = DIV_WAIT;
                w_ncnt   = CW'(DIV_LAT - 1);
              end else begin
                w_nvalid = 1'b1;
              end
            end
          end
        end
        DIV_WAIT: begin
          // The result is published on the edge where the counter reaches zero.
          if (r_cnt <= CW'(1)) begin
            w_nstate = RUN;
            w_ncnt   = '0;
            w_nvalid = 1'b1;
          end else begin
            w_ncnt = r_cnt - CW'(1);
          end
        end
        default: w_nstate = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctl       <= '0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= w_nvalid;
      r_illegal   <= w_nill;
      if (w_zero) begin
        r_ctl <= '0;
      end else if (w_load) begin
        r_ctl <= w_dec;
        r_rd  <= rd;
      end
    end
  end

  assign in_ready     = w_ready;
  assign out_valid    = r_out_valid;
  assign illegal      = r_illegal;
  assign div_busy     = (r_state == DIV_WAIT);
  assign BranchSelect = r_ctl.bsel;
  assign ExtendSelect = r_ctl.ext;
  assign ALUOpBSelect = r_ctl.alub;
  assign ALUControl   = r_ctl.aluc;
  assign WBSelect     = r_ctl.wbsel;
  assign RegFileWE    = r_ctl.rfwe  & r_out_valid;
  assign MemWE        = r_ctl.memwe & r_out_valid;
  assign SetFlags     = r_ctl.setf  & r_out_valid;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: decode table, load-use bubble, divide hold, flush, illegal, reset.
module tb_control_unit_pipe;
  localparam int OP_W = 5, REG_W = 4, DIV_LAT = 4;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, flush;
  logic [OP_W-1:0]  OpCode;
  logic [REG_W-1:0] rs_a, rs_b, rd;
  logic             out_valid, RegFileWE, ALUOpBSelect, SetFlags, MemWE, WBSelect, illegal, div_busy;
  logic [1:0]       BranchSelect, ExtendSelect, ALUControl;
  logic [10:0]      bund;
  int               n_tests = 0, n_fail = 0;

  control_unit_pipe #(.OP_W(OP_W), .REG_W(REG_W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .OpCode(OpCode),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .flush(flush), .out_valid(out_valid),
    .BranchSelect(BranchSelect), .RegFileWE(RegFileWE), .ExtendSelect(ExtendSelect),
    .ALUOpBSelect(ALUOpBSelect), .ALUControl(ALUControl), .SetFlags(SetFlags), .MemWE(MemWE),
    .WBSelect(WBSelect), .illegal(illegal), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  // bsel[2] rfwe ext[2] alub aluc[2] setf memwe wbsel
  assign bund = {BranchSelect, RegFileWE, ExtendSelect, ALUOpBSelect, ALUControl, SetFlags, MemWE, WBSelect};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [REG_W-1:0] a,
                       input logic [REG_W-1:0] b, input logic [REG_W-1:0] d);
    in_valid = v; OpCode = op; rs_a = a; rs_b = b; rd = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_bundle", bund, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1; #1;
    chk("rel_ready", in_ready, 1);

    // back-to-back 8,9,A,C
    drive(1'b1, 5'h08, 4'd1, 4'd2, 4'd5); tick;
    chk("op8_valid", out_valid, 1);
    chk("op8_bund", bund, 11'b00_1_00_0_00_0_0_0);
    drive(1'b1, 5'h09, 4'd1, 4'd2, 4'd5); tick;
    chk("op9_valid", out_valid, 1);
    chk("op9_bund", bund, 11'b00_1_01_1_00_0_0_0);
    drive(1'b1, 5'h0A, 4'd1, 4'd2, 4'd5); tick;
    chk("opA_valid", out_valid, 1);
    chk("opA_bund", bund, 11'b00_1_00_0_01_0_0_0);
    drive(1'b1, 5'h0C, 4'd1, 4'd2, 4'd5); tick;
    chk("opC_valid", out_valid, 1);
    chk("opC_bund", bund, 11'b00_1_00_0_11_0_0_0);
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0); tick;
    chk("idle_valid", out_valid, 0);
    chk("idle_gated", bund, 11'b00_0_00_0_11_0_0_0);

    // branch and store decode
    drive(1'b1, 5'h02, 4'd1, 4'd2, 4'd0); tick;
    chk("br2_bund", bund, 11'b10_0_10_0_01_1_0_0);
    drive(1'b1, 5'h06, 4'd1, 4'd2, 4'd0); tick;
    chk("st6_bund", bund, 11'b00_0_00_0_00_0_1_0);
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0); tick;

    // load-use hazard
    drive(1'b1, 5'h04, 4'd0, 4'd0, 4'd3); tick;
    chk("ld_valid", out_valid, 1);
    chk("ld_bund", bund, 11'b00_1_00_0_00_0_0_1);
    drive(1'b1, 5'h08, 4'd3, 4'd1, 4'd6); #1;
    chk("stall_ready", in_ready, 0);
    tick;
    chk("bubble_valid", out_valid, 0);
    chk("bubble_we", RegFileWE, 0);
    chk("post_stall_ready", in_ready, 1);
    tick;
    chk("add_issue_valid", out_valid, 1);
    chk("add_issue_bund", bund, 11'b00_1_00_0_00_0_0_0);

    // flush with accept
    drive(1'b1, 5'h08, 4'd1, 4'd2, 4'd4); flush = 1'b1; #1;
    chk("flush_ready", in_ready, 1);
    tick; flush = 1'b0;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    chk("flush_valid", out_valid, 0);
    chk("flush_we", RegFileWE, 0);

    // illegal opcodes
    drive(1'b1, 5'h0E, 4'd1, 4'd2, 4'd3); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    chk("ilE_pulse", illegal, 1);
    chk("ilE_valid", out_valid, 0);
    chk("ilE_bund", bund, 0);
    tick;
    chk("ilE_once", illegal, 0);
    drive(1'b1, 5'h18, 4'd1, 4'd2, 4'd3); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    chk("ilhi_pulse", illegal, 1);
    chk("ilhi_valid", out_valid, 0);
    tick;
    chk("ilhi_once", illegal, 0);

    // divide, DIV_LAT=4
    drive(1'b1, 5'h0B, 4'd1, 4'd2, 4'd7); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("div%0d_busy", i), div_busy, 1);
      chk($sformatf("div%0d_ready", i), in_ready, 0);
      chk($sformatf("div%0d_valid", i), out_valid, 0);
      chk($sformatf("div%0d_we", i), RegFileWE, 0);
      chk($sformatf("div%0d_aluc", i), ALUControl, 2'b10);
      tick;
    end
    chk("div4_valid", out_valid, 1);
    chk("div4_bund", bund, 11'b00_1_00_0_10_0_0_0);
    chk("div4_busy", div_busy, 0);
    tick;
    chk("div5_valid", out_valid, 0);

    // flush in second divide cycle
    drive(1'b1, 5'h0B, 4'd1, 4'd2, 4'd7); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    tick;
    chk("dflush_busy_pre", div_busy, 1);
    flush = 1'b1; tick; flush = 1'b0;
    chk("dflush_valid", out_valid, 0);
    chk("dflush_busy", div_busy, 0);
    chk("dflush_ready", in_ready, 1);
    tick; tick;
    chk("dflush_no_late", out_valid, 0);

    // reset mid divide
    drive(1'b1, 5'h0B, 4'd1, 4'd2, 4'd7); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    tick;
    rst_n = 1'b0; tick;
    chk("drst_valid", out_valid, 0);
    chk("drst_busy", div_busy, 0);
    chk("drst_bund", bund, 0);
    chk("drst_illegal", illegal, 0);
    chk("drst_ready", in_ready, 0);
    rst_n = 1'b1; #1;
    chk("drst_rel_ready", in_ready, 1);
    tick; tick; tick;
    chk("drst_no_ghost", out_valid, 0);
    drive(1'b1, 5'h0A, 4'd1, 4'd2, 4'd5); tick;
    drive(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    chk("drst_resume", bund, 11'b00_1_00_0_01_0_0_0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
